// File: rtl/fpc_accumulator_pkg.sv
// Shared types and width/limit helpers for the complex frame accumulator.
// Saturation limits are consumed only when FPC_ACCUMULATOR_SAT_EN is defined.
package fpc_accumulator_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    SEND = 1'b1
  } state_e;

  // Wide enough to hold m worst-case n-bit operands plus a guard bit.
  function automatic int acc_width(input int n, input int m);
    return n + $clog2(m) + 1;
  endfunction

  function automatic int count_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Limits are returned in 64 bits; callers narrow them to their own width.
  function automatic logic signed [63:0] sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/fpc_accumulator_if.sv
// Product-in / sum-out val/rdy bundle for the complex frame accumulator.
interface fpc_accumulator_if #(
  parameter int n = 32
) ();

  logic         recv_val;
  logic         recv_rdy;
  logic [n-1:0] in_r;
  logic [n-1:0] in_c;
  logic         send_val;
  logic         send_rdy;
  logic [n-1:0] sr;
  logic [n-1:0] sc;

  modport master (
    output recv_val, in_r, in_c, send_rdy,
    input  recv_rdy, send_val, sr, sc
  );

  modport slave (
    input  recv_val, in_r, in_c, send_rdy,
    output recv_rdy, send_val, sr, sc
  );

endinterface

// File: rtl/fpc_acc_lane.sv
// One accumulator lane: wide signed sum, clear on delivery, n-bit output register.
// FPC_ACCUMULATOR_SAT_EN selects saturation instead of wrap-around on output.
module fpc_acc_lane
  import fpc_accumulator_pkg::*;
#(
  parameter int n = 32,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         add_en,
  input  logic         last,
  input  logic         clr,
  input  logic [n-1:0] din,
  output logic [n-1:0] dout
);

  localparam int acc_w = acc_width(n, m);

`ifdef FPC_ACCUMULATOR_SAT_EN
  localparam logic signed [acc_w-1:0] hi_w = acc_w'(sat_max(n));
  localparam logic signed [acc_w-1:0] lo_w = acc_w'(sat_min(n));
`endif

  logic signed [acc_w-1:0] acc_q, acc_d, sum;
  logic        [n-1:0]     out_q, out_d, conv;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum = acc_q + {{(acc_w - n){din[n-1]}}, din};

`ifdef FPC_ACCUMULATOR_SAT_EN
    if (sum > hi_w)      conv = hi_w[n-1:0];
    else if (sum < lo_w) conv = lo_w[n-1:0];
    else                 conv = sum[n-1:0];
`else
    conv = sum[n-1:0];
`endif

    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (add_en) acc_d = sum;

    out_d = out_q;
    if (last) out_d = conv;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/fpc_accumulator.sv
// Streaming complex accumulator: sums m products per frame, then holds the result.
// Define FPC_ACCUMULATOR_SAT_EN to saturate (instead of wrap) the n-bit outputs.
module fpc_accumulator
  import fpc_accumulator_pkg::*;
#(
  parameter int n = 32,
  parameter int d = 16,
  parameter int m = 8
) (
  input  logic             clk,
  input  logic             reset,
  fpc_accumulator_if.slave bus
);

  localparam int count_w = count_width(m);

  if (m < 1 || d < 0 || d >= n) begin : g_bad_cfg
    $error("fpc_accumulator: illegal parameters");
  end

  state_e             state_q, state_d;
  logic [count_w-1:0] count_q, count_d;
  logic               recv_rdy_q, recv_rdy_d;
  logic               send_val_q, send_val_d;
  logic               accept, last, send_done;

  // Handshake outputs come from flops, so recv_rdy only rises after reset is released.
  assign accept    = bus.recv_val & recv_rdy_q;
  assign last      = accept && (count_q == count_w'(m - 1));
  assign send_done = send_val_q & bus.send_rdy;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ACC: begin
        if (last) begin
          count_d = '0;
          state_d = SEND;
        end else if (accept) begin
          count_d = count_q + 1'b1;
        end
      end
      SEND: begin
        if (send_done) state_d = ACC;
      end
    endcase
    recv_rdy_d = (state_d == ACC);
    send_val_d = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ACC;
      count_q    <= '0;
      recv_rdy_q <= 1'b0;
      send_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      recv_rdy_q <= recv_rdy_d;
      send_val_q <= send_val_d;
    end
  end

  assign bus.recv_rdy = recv_rdy_q;
  assign bus.send_val = send_val_q;

  fpc_acc_lane #(.n(n), .m(m)) u_lane_r (
    .clk    (clk),
    .reset  (reset),
    .add_en (accept),
    .last   (last),
    .clr    (send_done),
    .din    (bus.in_r),
    .dout   (bus.sr)
  );

  fpc_acc_lane #(.n(n), .m(m)) u_lane_c (
    .clk    (clk),
    .reset  (reset),
    .add_en (accept),
    .last   (last),
    .clr    (send_done),
    .din    (bus.in_c),
    .dout   (bus.sc)
  );

endmodule

// File: doc/fpc_accumulator.md
# fpc_accumulator

Streaming complex fixed-point accumulator placed directly downstream of the iterative complex multiplier. It consumes a stream of complex products (real, imaginary) over a val/rdy handshake and sums each frame of `m` consecutive products into one complex result. It then presents that result on a val/rdy output interface. Typical use is the reduction step of a complex dot product or correlation, in front of the next processing stage.

## Interface
- `n`, default 32: bit width of every data word, two's-complement signed.
- `d`, default 16: number of fractional bits. Addition does not depend on `d`; it only fixes the interpretation of values (1.0 = 2^d).
- `m`, default 8: number of products per frame. Legal range is m ≥ 1.

- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low: reset = 0 at a rising edge resets the block.
- `recv_val`  in  1  upstream product valid.
- `recv_rdy`  out  1  block can accept a product.
- `in_r`  in  n  real part of incoming product.
- `in_c`  in  n  imaginary part of incoming product.
- `send_val`  out  1  frame sum valid.
- `send_rdy`  in  1  downstream accepts sum.
- `sr`  out  n  real part of frame sum.
- `sc`  out  n  imaginary part of frame sum.

## Operation
- **FSM states:** ACC and SEND.
  - ACC: `recv_rdy`=1, `send_val`=0.
  - SEND: `recv_rdy`=0, `send_val`=1.
- **Accept:** an accept is `recv_val & recv_rdy` at a rising edge.
  - Each accept adds `in_r` to the real accumulator and `in_c` to the imaginary accumulator, and increments `count`.
  - Cycles with `recv_val`=0 are bubbles; they change nothing.
- **Frame end:** on the accept that makes `count` = m, the final sum is registered into `sr`/`sc`, `count` returns to 0, and the FSM goes to SEND.
- **Hold in SEND:** `sr`, `sc` and `send_val` hold stable until `send_val & send_rdy`.
  - On that edge the FSM returns to ACC.
  - Both accumulators are cleared on that same edge.
- **No overlap:** there is no acceptance during SEND. A product offered in SEND stalls upstream.
- **Accumulator width:** internal accumulators are n + clog2(m) + 1 bits, sign-extended from `in_r`/`in_c`. No intermediate overflow is possible.
- **Output conversion:** the n-bit output is formed from the wide sum per the Configuration section.
- **m = 1:** every accept goes straight to SEND. `count` is at least 1 bit wide.
- **Reset:** reset = 0 at any edge, including mid-frame or during SEND, does the following:
  - state ← ACC, count ← 0, both accumulators ← 0, `sr` ← 0, `sc` ← 0.
  - Any partial sum or undelivered result is discarded.
  - While reset is held low, `recv_rdy`=0 and `send_val`=0.

## Timing
- **Reset values:** `recv_rdy`=0, `send_val`=0, `sr`=0, `sc`=0.
- **After reset:** `recv_rdy`=1 in the first cycle after reset is released.
- **Latency:** `send_val` rises one cycle after the m-th accept edge.
- **Throughput:** minimum m+1 cycles per frame when `recv_val` and `send_rdy` are held high.
- **Registered outputs:** `sr`/`sc` are registered. `recv_rdy`/`send_val` decode from the state register only, with no combinational path from `recv_val` or `send_rdy`.
- **Same-cycle events:** an accept cannot coincide with a send, because they are mutually exclusive by state. A send-complete edge clears the accumulators before the next accept, which occurs one cycle later at the earliest.

## Configuration
- Macro: `FPC_ACCUMULATOR_SAT_EN`.
- **Defined:** each lane saturates the wide sum to the n-bit range.
  - Sums above 2^(n-1)-1 give 0x7FF…F.
  - Sums below -2^(n-1) give 0x800…0.
- **Undefined:** each lane truncates to the low n bits (two's-complement wrap-around).

## Structure
- **Shared package `fpc_accumulator_pkg`:**
  - The state enum typedef (ACC, SEND).
  - A width helper function returning n + clog2(m) + 1.
  - The n-bit saturation limits as functions of n.
- **Sub-module `fpc_acc_lane`:** one lane covering the wide accumulator, add/clear control and n-bit output conversion (saturate or truncate). It is instantiated twice, for real and imaginary.
- **Top level:** contains the FSM, the counter and the handshake logic.

## Test plan
- **Basic frame** (m=4, n=32, d=16): 4 accepts of (0x00010000, 0x00008000) → `sr`=0x00040000, `sc`=0x00020000. `send_val` rises one cycle after the 4th accept.
- **Backpressure:** hold `send_rdy`=0 for 5 cycles in SEND → `sr`/`sc` stable, `recv_rdy`=0, offered products are not counted. The next frame sum excludes them.
- **Overflow** (m=4):
  - Real inputs 0x7FFF0000 ×4: with SAT_EN `sr`=0x7FFFFFFF; without it `sr`=0xFFFC0000.
  - Imaginary inputs 0x80000000 ×4: with SAT_EN `sc`=0x80000000; without it `sc`=0x00000000.
- **Bubbles:** the same 4 products as the basic frame with `recv_val` low for 3 cycles between them → identical sums, and SEND is entered only after the 4th accept.
- **Reset mid-frame:** 2 accepts of (0x00010000, 0), reset low for one edge, then 4 accepts of (0x00010000, 0) → `sr`=0x00040000.
- **Back-to-back frames** (m=1): `recv_val`=1 and `send_rdy`=1 continuously with inputs 1, 2, 3 → outputs 1, 2, 3, one result every 2 cycles.
